// File: rtl/alu_writeback_stage_if.sv
// Bundle between the ALU issue side and the writeback stage.
// With WB_FORWARD_EN defined, it also carries the wb-stage forwarding outputs.
interface alu_writeback_stage_if #(
  parameter int CNTW = 32
);
  // Issue has no ready signal. The stage accepts an op on every cycle that
  // iss_valid is high. iss_rd and iss_we are sampled in that same cycle, and
  // flush kills the op being issued together with everything in flight.
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_we;
  logic            flush;
  logic [31:0]     alu_result;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic [CNTW-1:0] retired;
`ifdef WB_FORWARD_EN
  logic            fwd_rs1_en;
  logic [31:0]     fwd_rs1_data;
  logic            fwd_rs2_en;
  logic [31:0]     fwd_rs2_data;
`endif

  modport master (
    output iss_valid, iss_rd, iss_we, flush, alu_result, rs1_addr, rs2_addr,
`ifdef WB_FORWARD_EN
    input  fwd_rs1_en, fwd_rs1_data, fwd_rs2_en, fwd_rs2_data,
`endif
    input  wb_we, wb_addr, wb_data, hazard_rs1, hazard_rs2, retired
  );

  modport slave (
    input  iss_valid, iss_rd, iss_we, flush, alu_result, rs1_addr, rs2_addr,
`ifdef WB_FORWARD_EN
    output fwd_rs1_en, fwd_rs1_data, fwd_rs2_en, fwd_rs2_data,
`endif
    output wb_we, wb_addr, wb_data, hazard_rs1, hazard_rs2, retired
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind a LAT-cycle ALU. It carries destination tags and writes the register file.
// It also reports RAW hazards and counts retired ops. Optional forwarding is enabled with WB_FORWARD_EN.
module alu_writeback_stage #(
  parameter int LAT  = 2,
  parameter int CNTW = 32
) (
  input logic                  clk,
  input logic                  Areset,
  alu_writeback_stage_if.slave bus
);

  // The tag stages cover the issue-to-result distance (LAT-1 registers), and the wb
  // register is the final stage, so issue-to-write is LAT cycles. LAT must be >= 2.
  localparam int NSTG = LAT - 1;

  logic [NSTG-1:0] tag_v_q,  tag_v_d;
  logic [NSTG-1:0] tag_we_q, tag_we_d;
  logic [4:0]      tag_rd_q [NSTG];
  logic [4:0]      tag_rd_d [NSTG];

  logic            wb_we_q,   wb_we_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic            wb_enter;
  logic            pipe_hit1, pipe_hit2;
  logic            wb_hit1,   wb_hit2;

  always_comb begin
    tag_v_d     = '0;
    tag_we_d    = tag_we_q;
    tag_rd_d    = tag_rd_q;
    tag_v_d[0]  = bus.iss_valid & ~bus.flush;
    tag_we_d[0] = bus.iss_we;
    tag_rd_d[0] = bus.iss_rd;
    for (int i = 1; i < NSTG; i++) begin
      tag_v_d[i]  = tag_v_q[i-1] & ~bus.flush;
      tag_we_d[i] = tag_we_q[i-1];
      tag_rd_d[i] = tag_rd_q[i-1];
    end
  end

  // A flush in the cycle the result matures still kills that op.
  // The wb register keeps its contents from the last op that completed.
  assign wb_enter = tag_v_q[NSTG-1] & ~bus.flush;

  always_comb begin
    wb_we_d   = wb_enter & tag_we_q[NSTG-1] & (tag_rd_q[NSTG-1] != 5'd0);
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    retired_d = retired_q;
    if (wb_enter) begin
      wb_addr_d = tag_rd_q[NSTG-1];
      wb_data_d = bus.alu_result;
      retired_d = retired_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (Areset) begin
      tag_v_q   <= '0;
      tag_we_q  <= '0;
      for (int i = 0; i < NSTG; i++) tag_rd_q[i] <= 5'd0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      retired_q <= '0;
    end else begin
      tag_v_q   <= tag_v_d;
      tag_we_q  <= tag_we_d;
      for (int i = 0; i < NSTG; i++) tag_rd_q[i] <= tag_rd_d[i];
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      retired_q <= retired_d;
    end
  end

  // A pending write to x0 is never a hazard, because x0 is hardwired.
  always_comb begin
    pipe_hit1 = 1'b0;
    pipe_hit2 = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (tag_v_q[i] && tag_we_q[i] && (tag_rd_q[i] == bus.rs1_addr)) pipe_hit1 = 1'b1;
      if (tag_v_q[i] && tag_we_q[i] && (tag_rd_q[i] == bus.rs2_addr)) pipe_hit2 = 1'b1;
    end
    pipe_hit1 = pipe_hit1 & (bus.rs1_addr != 5'd0);
    pipe_hit2 = pipe_hit2 & (bus.rs2_addr != 5'd0);
  end

  assign wb_hit1 = wb_we_q & (wb_addr_q == bus.rs1_addr) & (bus.rs1_addr != 5'd0);
  assign wb_hit2 = wb_we_q & (wb_addr_q == bus.rs2_addr) & (bus.rs2_addr != 5'd0);

`ifdef WB_FORWARD_EN
  // A younger in-flight write to the same register wins over the wb value.
  assign bus.hazard_rs1   = pipe_hit1;
  assign bus.hazard_rs2   = pipe_hit2;
  assign bus.fwd_rs1_en   = wb_hit1 & ~pipe_hit1;
  assign bus.fwd_rs2_en   = wb_hit2 & ~pipe_hit2;
  assign bus.fwd_rs1_data = wb_data_q;
  assign bus.fwd_rs2_data = wb_data_q;
`else
  assign bus.hazard_rs1   = pipe_hit1 | wb_hit1;
  assign bus.hazard_rs2   = pipe_hit2 | wb_hit2;
`endif

  assign bus.wb_we   = wb_we_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage. It uses a history-based model of issued ops and a per-cycle compare.
// CNTW=4 keeps the retire counter wrap reachable. WB_FORWARD_EN selects the forwarding checks.
module tb_alu_writeback_stage;
  localparam int LAT  = 2;
  localparam int CNTW = 4;
  localparam int MAXC = 2048;

  logic clk;
  logic Areset;

  alu_writeback_stage_if #(.CNTW(CNTW)) bus ();

  alu_writeback_stage #(.LAT(LAT), .CNTW(CNTW)) dut (
    .clk    (clk),
    .Areset (Areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Per-cycle stimulus history, indexed by the cycle the inputs were applied in.
  bit          h_iv  [MAXC];
  bit          h_we  [MAXC];
  bit          h_fl  [MAXC];
  bit          h_rst [MAXC];
  logic [4:0]  h_rd  [MAXC];
  logic [4:0]  h_rs1 [MAXC];
  logic [4:0]  h_rs2 [MAXC];
  logic [31:0] h_res [MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit iv, input logic [4:0] rd, input bit we,
                       input bit fl, input logic [31:0] res, input logic [4:0] r1,
                       input logic [4:0] r2);
    Areset         = rst;
    bus.iss_valid  = iv;
    bus.iss_rd     = rd;
    bus.iss_we     = we;
    bus.flush      = fl;
    bus.alu_result = res;
    bus.rs1_addr   = r1;
    bus.rs2_addr   = r2;
    h_rst[cyc] = rst; h_iv[cyc] = iv; h_rd[cyc] = rd; h_we[cyc] = we;
    h_fl[cyc]  = fl;  h_res[cyc] = res; h_rs1[cyc] = r1; h_rs2[cyc] = r2;
  endtask

  task automatic step(input bit rst, input bit iv, input logic [4:0] rd, input bit we,
                      input bit fl, input logic [31:0] res, input logic [4:0] r1,
                      input logic [4:0] r2);
    @(posedge clk);
    #1;
    if (cyc + 1 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc + 1, MAXC);
      $fatal(1);
    end
    cyc++;
    drive(rst, iv, rd, we, fl, res, r1, r2);
  endtask

  // An op issued in cycle t is still live at cycle c if no flush or reset was seen since.
  function automatic bit alive(input int t, input int c);
    if (t < 0) return 1'b0;
    if (!h_iv[t]) return 1'b0;
    for (int k = t; k < c; k++)
      if (h_fl[k] || h_rst[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit pipe_hit(input logic [4:0] rs, input int c);
    if (rs == 5'd0) return 1'b0;
    for (int t = c - LAT + 1; t < c; t++)
      if (alive(t, c) && h_we[t] && h_rd[t] == rs) return 1'b1;
    return 1'b0;
  endfunction

  bit              m_we;
  logic [4:0]      m_addr;
  logic [31:0]     m_data;
  logic [CNTW-1:0] m_cnt;

  always @(negedge clk) begin
    if (cyc >= 2) begin
      int  c;
      bit  p1, p2, w1, w2;
      c = cyc;
      if (h_rst[c-1]) begin
        m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
      end else if (alive(c - LAT, c)) begin
        m_cnt  = m_cnt + 1'b1;
        m_addr = h_rd[c-LAT];
        m_data = h_res[c-1];
        m_we   = h_we[c-LAT] && (h_rd[c-LAT] != 5'd0);
      end else begin
        m_we = 0;
      end
      p1 = pipe_hit(h_rs1[c], c);
      p2 = pipe_hit(h_rs2[c], c);
      w1 = m_we && m_addr == h_rs1[c] && h_rs1[c] != 5'd0;
      w2 = m_we && m_addr == h_rs2[c] && h_rs2[c] != 5'd0;
      chk("wb_we",   32'(bus.wb_we),   32'(m_we));
      chk("wb_addr", 32'(bus.wb_addr), 32'(m_addr));
      chk("wb_data", bus.wb_data,      m_data);
      chk("retired", 32'(bus.retired), 32'(m_cnt));
`ifdef WB_FORWARD_EN
      chk("hazard_rs1", 32'(bus.hazard_rs1), 32'(p1));
      chk("hazard_rs2", 32'(bus.hazard_rs2), 32'(p2));
      chk("fwd_rs1_en", 32'(bus.fwd_rs1_en), 32'(w1 && !p1));
      chk("fwd_rs2_en", 32'(bus.fwd_rs2_en), 32'(w2 && !p2));
      if (w1 && !p1) chk("fwd_rs1_data", bus.fwd_rs1_data, m_data);
      if (w2 && !p2) chk("fwd_rs2_data", bus.fwd_rs2_data, m_data);
`else
      chk("hazard_rs1", 32'(bus.hazard_rs1), 32'(p1 || w1));
      chk("hazard_rs2", 32'(bus.hazard_rs2), 32'(p2 || w2));
`endif
    end
  end

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, $urandom(), r1, r2);
  endtask

  initial begin
    m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    drive(1, 0, 5'd0, 0, 0, 32'd0, 5'd5, 5'd3);
    step(1, 0, 5'd0, 0, 0, 32'd0, 5'd5, 5'd3);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd5, 5'd3);
    #1;
    chk("lit_reset_wb_we",   32'(bus.wb_we), 32'd0);
    chk("lit_reset_wb_data", bus.wb_data,    32'd0);
    chk("lit_reset_retired", 32'(bus.retired), 32'd0);
    chk("lit_reset_hz1",     32'(bus.hazard_rs1), 32'd0);
    chk("lit_reset_hz2",     32'(bus.hazard_rs2), 32'd0);

    // Single write: rd=5 gets DEADBEEF, with the result arriving one cycle after issue.
    step(0, 1, 5'd5, 1, 0, 32'd0, 5'd5, 5'd0);
    step(0, 0, 5'd0, 0, 0, 32'hDEAD_BEEF, 5'd5, 5'd0);
    #1 chk("lit_t2_hz_inflight", 32'(bus.hazard_rs1), 32'd1);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd5, 5'd0);
    #1;
    chk("lit_t2_wb_we",   32'(bus.wb_we),   32'd1);
    chk("lit_t2_wb_addr", 32'(bus.wb_addr), 32'd5);
    chk("lit_t2_wb_data", bus.wb_data,      32'hDEAD_BEEF);
    chk("lit_t2_retired", 32'(bus.retired), 32'd1);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd5, 5'd0);
    #1 chk("lit_t2_wb_we_drop", 32'(bus.wb_we), 32'd0);

    // Back-to-back issue of rd=1,2,3 while decode keeps querying rs1=2.
    step(0, 1, 5'd1, 1, 0, 32'd0, 5'd2, 5'd3);
    step(0, 1, 5'd2, 1, 0, 32'h11, 5'd2, 5'd3);
    step(0, 1, 5'd3, 1, 0, 32'h22, 5'd2, 5'd3);
    #1;
    chk("lit_t3_hz_pipe", 32'(bus.hazard_rs1), 32'd1);
    chk("lit_t3_addr1",   32'(bus.wb_addr), 32'd1);
    chk("lit_t3_data1",   bus.wb_data, 32'h11);
    step(0, 0, 5'd0, 0, 0, 32'h33, 5'd2, 5'd3);
    #1;
    chk("lit_t3_addr2", 32'(bus.wb_addr), 32'd2);
    chk("lit_t3_data2", bus.wb_data, 32'h22);
`ifdef WB_FORWARD_EN
    chk("lit_t3_hz_wb",  32'(bus.hazard_rs1), 32'd0);
    chk("lit_t3_fwd_en", 32'(bus.fwd_rs1_en), 32'd1);
`else
    chk("lit_t3_hz_wb",  32'(bus.hazard_rs1), 32'd1);
`endif
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd2, 5'd3);
    #1;
    chk("lit_t3_addr3",   32'(bus.wb_addr), 32'd3);
    chk("lit_t3_data3",   bus.wb_data, 32'h33);
    chk("lit_t3_hz_done", 32'(bus.hazard_rs1), 32'd0);
    chk("lit_t3_retired", 32'(bus.retired), 32'd4);

    // A write to x0 still retires, but it never writes and never raises a hazard.
    step(0, 1, 5'd0, 1, 0, 32'd0, 5'd0, 5'd0);
    step(0, 0, 5'd0, 0, 0, 32'h77, 5'd0, 5'd0);
    #1 chk("lit_t4_hz_x0", 32'(bus.hazard_rs1), 32'd0);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("lit_t4_wb_we",   32'(bus.wb_we), 32'd0);
    chk("lit_t4_retired", 32'(bus.retired), 32'd5);

    // A flush kills rd=7 in flight.
    step(0, 1, 5'd7, 1, 0, 32'd0, 5'd7, 5'd0);
    step(0, 0, 5'd0, 0, 1, 32'h99, 5'd7, 5'd0);
    #1 chk("lit_t5_hz_before", 32'(bus.hazard_rs1), 32'd1);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd7, 5'd0);
    #1;
    chk("lit_t5_hz_after", 32'(bus.hazard_rs1), 32'd0);
    chk("lit_t5_wb_we",    32'(bus.wb_we), 32'd0);
    chk("lit_t5_retired",  32'(bus.retired), 32'd5);

    // Random traffic with a small register range so that hazards collide often.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Counter wrap 15 -> 0, then a reset with two ops in flight.
    step(1, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 15; i++) step(0, 1, 5'(i + 1), 1, 0, $urandom(), 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);
    #1 chk("lit_t6_retired15", 32'(bus.retired), 32'd15);
    step(0, 1, 5'd4, 1, 0, $urandom(), 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);
    #1 chk("lit_t6_wrap", 32'(bus.retired), 32'd0);
    step(0, 1, 5'd9,  1, 0, 32'd0, 5'd9, 5'd10);
    step(1, 1, 5'd10, 1, 0, 32'h55, 5'd9, 5'd10);
    step(0, 0, 5'd0,  0, 0, 32'h66, 5'd9, 5'd10);
    #1;
    chk("lit_t6_rst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("lit_t6_rst_ret",   32'(bus.retired), 32'd0);
    chk("lit_t6_rst_hz1",   32'(bus.hazard_rs1), 32'd0);
    step(0, 0, 5'd0, 0, 0, 32'd0, 5'd9, 5'd10);
    #1;
    chk("lit_t6_rst_wb_we2", 32'(bus.wb_we), 32'd0);
    chk("lit_t6_rst_ret2",   32'(bus.retired), 32'd0);
    chk("lit_t6_rst_hz2",    32'(bus.hazard_rs2), 32'd0);

    idle(3, 5'd1, 5'd2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
